// File: rtl/led_pwm_pkg.sv
// Shared types and the saturating fade helper for the LED PWM output stage.
package led_pwm_pkg;

    localparam int unsigned DEFAULT_PWM_BITS = 8;
    localparam int unsigned FADE_W           = 16;

    typedef logic [DEFAULT_PWM_BITS-1:0] duty_t;
    typedef logic [FADE_W-1:0]           fade_t;

    localparam duty_t DUTY_MAX = '1;

    // One saturated step of duty toward target; step 0 jumps straight there.
    function automatic fade_t fade_next(input fade_t duty, input fade_t target, input fade_t step);
        logic [FADE_W:0] sum;
        logic [FADE_W:0] gap;
        sum       = {1'b0, duty} + {1'b0, step};
        gap       = {1'b0, duty} - {1'b0, target};
        fade_next = duty;
        if (step == '0) begin
            fade_next = target;
        end else if (duty < target) begin
            fade_next = (sum >= {1'b0, target}) ? target : sum[FADE_W-1:0];
        end else if (duty > target) begin
            fade_next = (gap <= {1'b0, step}) ? target : (duty - step);
        end
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: holds the ramping duty and produces the registered PWM drive.
module led_fade_channel
    import led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS
) (
    input  logic                clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_wrap,
    input  logic                i_on,
    input  logic [PWM_BITS-1:0] i_brightness,
    input  logic [PWM_BITS-1:0] i_fade_step,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic                o_led
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] target_c;
    logic [PWM_BITS-1:0] duty_next_c;

    always_comb begin
        target_c    = i_on ? i_brightness : '0;
        duty_next_c = PWM_BITS'(fade_next(FADE_W'(duty), FADE_W'(target_c), FADE_W'(i_fade_step)));
    end

    // Full-scale duty is forced high so the LED never blinks off for a tick.
    always_ff @(posedge clk) begin
        if (i_reset || i_clear) begin
            duty  <= '0;
            o_led <= 1'b0;
        end else begin
            if (i_wrap) begin
                duty <= duty_next_c;
            end
            o_led <= (duty == CNT_MAX) || (i_pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/led_pwm_fader.sv
// LED output stage: shared prescaler and PWM counter driving per-channel fading PWM.
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned PWM_BITS   = $bits(duty_t),
    parameter int unsigned PRESCALE   = 195
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [WORD_WIDTH-1:0] i_pattern,
    input  logic [PWM_BITS-1:0]   i_brightness,
    input  logic [PWM_BITS-1:0]   i_fade_step,
    output logic [WORD_WIDTH-1:0] o_leds,
    output logic                  o_period_start
);

    localparam int unsigned         PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]     prescaler;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                clear_c;
    logic                tick_c;
    logic                wrap_c;

    always_comb begin
        clear_c = ~i_enable;
        tick_c  = (prescaler == PS_LAST);
        wrap_c  = tick_c && (pwm_cnt == CNT_MAX);
    end

    // Disable clears everything exactly like reset so fades restart from zero.
    always_ff @(posedge clk) begin
        if (i_reset || clear_c) begin
            prescaler      <= '0;
            pwm_cnt        <= '0;
            o_period_start <= 1'b0;
        end else begin
            prescaler      <= tick_c ? '0 : (prescaler + PS_W'(1));
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end
            o_period_start <= wrap_c;
        end
    end

    for (genvar i = 0; i < int'(WORD_WIDTH); i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk          (clk),
            .i_reset      (i_reset),
            .i_clear      (clear_c),
            .i_wrap       (wrap_c),
            .i_on         (i_pattern[i]),
            .i_brightness (i_brightness),
            .i_fade_step  (i_fade_step),
            .i_pwm_cnt    (pwm_cnt),
            .o_led        (o_leds[i])
        );
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench: cycle model scoreboard plus per-period duty table and prescale sequence.
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] pat;
    logic [3:0] bri;
    logic [3:0] stp;
    logic [7:0] leds1;
    logic [7:0] leds3;
    logic       ps1;
    logic       ps3;

    always #5 clk = ~clk;

    led_pwm_fader #(.WORD_WIDTH(8), .PWM_BITS(4), .PRESCALE(1)) dut1 (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_pattern(pat),
        .i_brightness(bri), .i_fade_step(stp), .o_leds(leds1), .o_period_start(ps1)
    );

    led_pwm_fader #(.WORD_WIDTH(8), .PWM_BITS(4), .PRESCALE(3)) dut3 (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_pattern(pat),
        .i_brightness(bri), .i_fade_step(stp), .o_leds(leds3), .o_period_start(ps3)
    );

    typedef struct packed {
        logic [7:0] leds;
        logic       ps;
    } exp_t;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] bri;
        logic [3:0] stp;
        int         chg_at;
        logic [7:0] chg_pat;
        int         ch;
        int         exp_cnt;
        int         exp_other;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_cnt = 0;
    int   m_duty[8];
    int   win_cnt[8];

    function automatic int fade(input int d, input int t, input int s);
        if (s == 0) return t;
        if (d < t) return (d + s > t) ? t : d + s;
        if (d > t) return (d - s < t) ? t : d - s;
        return d;
    endfunction

    function automatic vec_t mk(input logic [7:0] p, input logic [3:0] b, input logic [3:0] s,
                                input int ca, input logic [7:0] cp, input int ch, input int ec, input int eo);
        vec_t v;
        v.pat = p; v.bri = b; v.stp = s; v.chg_at = ca; v.chg_pat = cp;
        v.ch = ch; v.exp_cnt = ec; v.exp_other = eo;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the expected dut1 outputs are queued before the edge and checked after it.
    task automatic step();
        exp_t e;
        e = '0;
        if (rst || !en) begin
            m_cnt = 0;
            for (int i = 0; i < 8; i++) m_duty[i] = 0;
        end else begin
            for (int i = 0; i < 8; i++) e.leds[i] = (m_duty[i] == 15) || (m_cnt < m_duty[i]);
            e.ps = (m_cnt == 15);
            if (m_cnt == 15)
                for (int i = 0; i < 8; i++) m_duty[i] = fade(m_duty[i], pat[i] ? int'(bri) : 0, int'(stp));
            m_cnt = (m_cnt + 1) % 16;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_leds", int'(leds1), int'(e.leds));
        check("sb_period_start", int'(ps1), int'(e.ps));
    endtask

    // One 16-cycle PWM window of dut1 starting on a period-start cycle.
    task automatic window(input int chg_at, input logic [7:0] chg_pat);
        for (int c = 0; c < 8; c++) win_cnt[c] = 0;
        for (int j = 1; j <= 16; j++) begin
            step();
            for (int c = 0; c < 8; c++) win_cnt[c] += int'(leds1[c]);
            if (j == chg_at) pat = chg_pat;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        int cnt;
        int other;

        tbl[0]  = mk(8'h01, 4'd4,  4'd0, 0,  8'h00, 0, 4,  0);
        tbl[1]  = mk(8'h80, 4'd15, 4'd5, 0,  8'h00, 0, 4,  0);
        tbl[2]  = mk(8'h80, 4'd15, 4'd5, 0,  8'h00, 7, 5,  0);
        tbl[3]  = mk(8'h80, 4'd15, 4'd5, 0,  8'h00, 7, 10, 0);
        tbl[4]  = mk(8'h80, 4'd15, 4'd5, 0,  8'h00, 7, 16, 0);
        tbl[5]  = mk(8'h00, 4'd15, 4'd6, 0,  8'h00, 7, 16, 0);
        tbl[6]  = mk(8'h00, 4'd15, 4'd6, 0,  8'h00, 7, 9,  0);
        tbl[7]  = mk(8'h00, 4'd15, 4'd6, 0,  8'h00, 7, 3,  0);
        tbl[8]  = mk(8'h00, 4'd15, 4'd6, 0,  8'h00, 7, 0,  0);
        tbl[9]  = mk(8'h00, 4'd8,  4'd0, 7,  8'h02, 1, 0,  0);
        tbl[10] = mk(8'h02, 4'd8,  4'd0, 15, 8'h00, 1, 8,  0);
        tbl[11] = mk(8'h02, 4'd8,  4'd0, 0,  8'h00, 1, 0,  0);
        tbl[12] = mk(8'h02, 4'd8,  4'd0, 0,  8'h00, 1, 8,  0);
        tbl[13] = mk(8'hFF, 4'd15, 4'd0, 0,  8'h00, 1, 8,  0);
        tbl[14] = mk(8'h0F, 4'd15, 4'd0, 0,  8'h00, 0, 16, 112);
        tbl[15] = mk(8'h0F, 4'd15, 4'd0, 0,  8'h00, 7, 0,  64);

        // Reset with random inputs
        rst = 1'b1;
        en  = 1'($urandom);
        pat = 8'($urandom);
        bri = 4'($urandom);
        stp = 4'($urandom);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_leds", int'(leds1), 0);
            check("rst_period_start", int'(ps1), 0);
            check("rst_leds_p3", int'(leds3), 0);
            pat = 8'($urandom);
        end

        rst = 1'b0; en = 1'b1; pat = 8'h01; bri = 4'd4; stp = 4'd0;
        j = 0;
        do begin step(); j++; end while (!ps1 && j < 40);
        check("first_period_start", j, 16);

        // Per-period duty table
        for (int r = 0; r < 16; r++) begin
            pat = tbl[r].pat; bri = tbl[r].bri; stp = tbl[r].stp;
            window(tbl[r].chg_at, tbl[r].chg_pat);
            other = 0;
            for (int c = 0; c < 8; c++) if (c != tbl[r].ch) other += win_cnt[c];
            check($sformatf("row%0d_ch%0d_high", r, tbl[r].ch), win_cnt[tbl[r].ch], tbl[r].exp_cnt);
            check($sformatf("row%0d_other_high", r), other, tbl[r].exp_other);
            check($sformatf("row%0d_period_start", r), int'(ps1), 1);
        end

        // Prescale = 3: period length, disable mid-fade, fade restart
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b1; pat = 8'h80; bri = 4'd15; stp = 4'd5;
        j = 0;
        do begin step(); j++; end while (!ps3 && j < 200);
        check("p3_first_pulse", j, 48);

        j = 0; cnt = 0;
        do begin step(); j++; cnt += int'(leds3[7]); end while (!ps3 && j < 200);
        check("p3_period", j, 48);
        check("p3_duty5_high", cnt, 15);

        en = 1'b0;
        step();
        check("p3_disable_leds", int'(leds3), 0);
        check("p3_disable_period_start", int'(ps3), 0);
        en = 1'b1;

        j = 0; cnt = 0;
        do begin step(); j++; cnt += int'(leds3[7]); end while (!ps3 && j < 200);
        check("p3_reenable_pulse", j, 48);
        check("p3_restart_duty0_high", cnt, 0);

        j = 0; cnt = 0;
        do begin step(); j++; cnt += int'(leds3[7]); end while (!ps3 && j < 200);
        check("p3_period_after_reenable", j, 48);
        check("p3_restart_duty5_high", cnt, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
